// File: rtl/case_vector_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : case_seq_pkg
// Brief    : Shared types and constants for the case-vector sequencer.
//            The sweep covers every {a,b,c,d} pattern of the 4-input decoder.
// Revision : 1.0 - initial release
// ============================================================================
package case_seq_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int RES_W   = 2 * NUM_VEC;

    // Explicit 2-bit encoding so the state register width is fixed.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/case_vector_sequencer_hold_timer.sv
`default_nettype none
// ============================================================================
// Module   : case_hold_timer
// Brief    : Loadable down-counter that measures how long a vector is held.
//            Load reloads HOLD_CYCLES-1; enable decrements and stops at zero.
//            The zero flag tells the sequencer the hold period has expired.
// Revision : 1.0 - initial release
// ============================================================================
module case_hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_en,
    output logic o_zero
);

    // Counter must hold HOLD_CYCLES-1; never narrower than one bit.
    localparam int c_CNT_W = ($clog2(HOLD_CYCLES + 1) < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_RELOAD = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE    = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    // Load wins over decrement; the count parks at zero until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= c_RELOAD;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - c_ONE;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/case_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : case_vector_sequencer
// Brief    : Clocked, restartable sweep of all 16 {a,b,c,d} patterns into the
//            parallel-case decoder. Each pattern is held HOLD_CYCLES cycles,
//            then y/z are captured into result[2k+1:2k] for vector k.
//            HOLD_CYCLES legal range is 1..255; NUM_VEC must stay 16.
// Revision : 1.0 - initial release
// ============================================================================
module case_vector_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int NUM_VEC     = case_seq_pkg::NUM_VEC
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    output logic [case_seq_pkg::VEC_W-1:0] vec_out,
    output logic                           vec_valid,
    input  logic                           y_in,
    input  logic                           z_in,
    output logic                           busy,
    output logic                           done,
    output logic [2*NUM_VEC-1:0]           result,
    output logic [4:0]                     count
);

    import case_seq_pkg::*;

    localparam logic [VEC_W-1:0] c_LAST_VEC  = VEC_W'(NUM_VEC - 1);
    localparam logic [4:0]       c_COUNT_MAX = 5'(NUM_VEC);
    localparam logic [4:0]       c_COUNT_ONE = 5'd1;
    localparam logic [VEC_W-1:0] c_VEC_ONE   = VEC_W'(1);

    state_t               r_state;
    logic [VEC_W-1:0]     r_vec;
    logic                 r_valid;
    logic                 r_busy;
    logic                 r_done;
    logic [2*NUM_VEC-1:0] r_result;
    logic [4:0]           r_count;

    logic w_start_ok;
    logic w_last;
    logic w_timer_load;
    logic w_timer_en;
    logic w_timer_zero;

    // A start is only honoured when no sweep is in flight, and abort vetoes it.
    assign w_start_ok   = start && !abort && ((r_state == IDLE) || (r_state == DONE));
    assign w_last       = (r_vec == c_LAST_VEC);
    // Reload on a fresh sweep or when stepping to the next vector.
    assign w_timer_load = w_start_ok || ((r_state == SAMPLE) && !abort && !w_last);
    assign w_timer_en   = (r_state == DRIVE) && !abort;

    case_hold_timer #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_timer_load),
        .i_en   (w_timer_en),
        .o_zero (w_timer_zero)
    );

    // Sweep FSM with all status flags registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_vec    <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
            r_count  <= '0;
        end else if (abort) begin
            // Partial result and count are left visible for debug.
            r_state <= IDLE;
            r_vec   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state  <= DRIVE;
                        r_vec    <= '0;
                        r_valid  <= 1'b1;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_result <= '0;
                        r_count  <= '0;
                    end
                end
                DRIVE: begin
                    if (w_timer_zero) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_result[{r_vec, 1'b0} +: 2] <= {y_in, z_in};
                    if (r_count != c_COUNT_MAX) begin
                        r_count <= r_count + c_COUNT_ONE;
                    end
                    if (w_last) begin
                        // Vector stays at the last pattern; no wrap to 0.
                        r_state <= DONE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= DRIVE;
                        r_vec   <= r_vec + c_VEC_ONE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign vec_out   = r_vec;
    assign vec_valid = r_valid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign result    = r_result;
    assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_case_vector_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_case_vector_sequencer
// Brief    : Directed bench for case_vector_sequencer. One instance runs with
//            HOLD_CYCLES=4 against a code5a decoder model (y=a&b, z=c&d only
//            when the first casez arm misses); a second runs HOLD_CYCLES=1
//            with y tied high and z tied low.
// Revision : 1.0 - initial release
// ============================================================================
module tb_case_vector_sequencer;

    logic        clk;
    logic        rst_n;

    // HOLD_CYCLES=4 instance
    logic        r_start;
    logic        r_abort;
    logic        r_z_inv;
    logic [3:0]  w_vec_out;
    logic        w_vec_valid;
    logic        w_y_in;
    logic        w_z_in;
    logic        w_busy;
    logic        w_done;
    logic [31:0] w_result;
    logic [4:0]  w_count;

    // HOLD_CYCLES=1 instance
    logic        r_start1;
    logic        r_abort1;
    logic        r_y1;
    logic        r_z1;
    logic [3:0]  w_vec_out1;
    logic        w_vec_valid1;
    logic        w_busy1;
    logic        w_done1;
    logic [31:0] w_result1;
    logic [4:0]  w_count1;

    int n_checks;
    int n_errors;

    // code5a: casez 4'b11?? sets y, else 4'b??11 sets z
    assign w_y_in = w_vec_out[3] & w_vec_out[2];
    assign w_z_in = (w_vec_out[1] & w_vec_out[0] & ~(w_vec_out[3] & w_vec_out[2])) ^ r_z_inv;

    case_vector_sequencer #(.HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (r_start),
        .abort     (r_abort),
        .vec_out   (w_vec_out),
        .vec_valid (w_vec_valid),
        .y_in      (w_y_in),
        .z_in      (w_z_in),
        .busy      (w_busy),
        .done      (w_done),
        .result    (w_result),
        .count     (w_count)
    );

    case_vector_sequencer #(.HOLD_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (r_start1),
        .abort     (r_abort1),
        .vec_out   (w_vec_out1),
        .vec_valid (w_vec_valid1),
        .y_in      (r_y1),
        .z_in      (r_z1),
        .busy      (w_busy1),
        .done      (w_done1),
        .result    (w_result1),
        .count     (w_count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        r_start = 1'b1;
        tick();
        r_start = 1'b0;
    endtask

    // Edges until done rises on the selected instance, bounded by limit.
    task automatic wait_done(input bit sel, input int limit, output int n);
        n = 0;
        while (((sel ? w_done1 : w_done) !== 1'b1) && (n < limit)) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int seq_bad;
        int rises;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        r_start  = 1'b0;
        r_abort  = 1'b0;
        r_z_inv  = 1'b0;
        r_start1 = 1'b0;
        r_abort1 = 1'b0;
        r_y1     = 1'b1;
        r_z1     = 1'b0;

        // Reset values
        repeat (2) tick();
        check("rst_vec",   32'(w_vec_out),   32'h0);
        check("rst_valid", 32'(w_vec_valid), 32'h0);
        check("rst_busy",  32'(w_busy),      32'h0);
        check("rst_done",  32'(w_done),      32'h0);
        check("rst_result", w_result,        32'h0);
        check("rst_count", 32'(w_count),     32'h0);
        check("rst_done1", 32'(w_done1),     32'h0);
        rst_n = 1'b1;
        tick();

        // Full sweep: vector j/5 visible j cycles after the start edge
        pulse_start();
        check("t1_busy", 32'(w_busy), 32'h1);
        seq_bad = 0;
        lat     = -1;
        for (int j = 0; j < 200; j++) begin
            if (j > 0) tick();
            if (w_done === 1'b1) begin
                lat = j;
                break;
            end
            if ((32'(w_vec_out) != 32'(j / 5)) || (w_vec_valid !== 1'b1)) seq_bad++;
        end
        check("t1_latency", 32'(lat),        32'd80);
        check("t1_seq",     32'(seq_bad),    32'd0);
        check("t1_count",   32'(w_count),    32'd16);
        check("t1_result",  w_result,        32'hAA40_4040);
        check("t1_vec",     32'(w_vec_out),  32'hF);
        check("t1_valid",   32'(w_vec_valid), 32'h0);
        check("t1_busy_end", 32'(w_busy),    32'h0);

        // Restart from DONE with z inverted
        r_z_inv = 1'b1;
        pulse_start();
        check("t5_cleared", w_result,     32'h0);
        check("t5_count0",  32'(w_count), 32'h0);
        check("t5_done0",   32'(w_done),  32'h0);
        wait_done(1'b0, 200, lat);
        check("t5_latency", 32'(lat),     32'd80);
        check("t5_result",  w_result,     32'hFF15_1515);
        r_z_inv = 1'b0;

        // Abort during DRIVE of vector 6
        pulse_start();
        repeat (30) tick();
        check("t3_vec6", 32'(w_vec_out), 32'h6);
        r_abort = 1'b1;
        tick();
        r_abort = 1'b0;
        check("t3_vec",    32'(w_vec_out),   32'h0);
        check("t3_valid",  32'(w_vec_valid), 32'h0);
        check("t3_busy",   32'(w_busy),      32'h0);
        check("t3_done",   32'(w_done),      32'h0);
        check("t3_count",  32'(w_count),     32'd6);
        check("t3_result", w_result,         32'h40);

        // start and abort together from IDLE: nothing happens
        r_start = 1'b1;
        r_abort = 1'b1;
        tick();
        r_start = 1'b0;
        r_abort = 1'b0;
        rises = 0;
        for (int k = 0; k < 8; k++) begin
            if (w_vec_valid !== 1'b0 || w_busy !== 1'b0) rises++;
            tick();
        end
        check("t4_no_sweep", 32'(rises), 32'd0);

        // start mid-sweep at vector 9 is ignored
        pulse_start();
        repeat (46) tick();
        r_start = 1'b1;
        tick();
        r_start = 1'b0;
        check("t4_vec9", 32'(w_vec_out), 32'h9);
        wait_done(1'b0, 200, lat);
        check("t4_latency", 32'(47 + lat), 32'd80);
        check("t4_result",  w_result,      32'hAA40_4040);

        // Asynchronous reset during SAMPLE of vector 12
        pulse_start();
        repeat (64) tick();
        check("t6_vec12", 32'(w_vec_out), 32'hC);
        #2 rst_n = 1'b0;
        #1;
        check("t6_vec",    32'(w_vec_out),   32'h0);
        check("t6_valid",  32'(w_vec_valid), 32'h0);
        check("t6_busy",   32'(w_busy),      32'h0);
        check("t6_result", w_result,         32'h0);
        check("t6_count",  32'(w_count),     32'h0);
        #2 rst_n = 1'b1;
        repeat (5) tick();
        check("t6_idle", 32'({w_busy, w_vec_valid, w_done}), 32'h0);

        // HOLD_CYCLES=1 with y=1, z=0
        r_start1 = 1'b1;
        tick();
        r_start1 = 1'b0;
        wait_done(1'b1, 200, lat);
        check("t2_latency", 32'(lat),      32'd32);
        check("t2_result",  w_result1,     32'hAAAA_AAAA);
        check("t2_count",   32'(w_count1), 32'd16);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/case_vector_sequencer.md
Name: case_vector_sequencer

Overview:
- Sequential stimulus/capture stage directly upstream of the 4-input parallel-case decoder (code5a).
- Drives the decoder's {a,b,c,d} inputs through all 16 patterns, 0000 to 1111, and holds each pattern for a programmable number of cycles.
- Samples the decoder's y/z outputs once per pattern and packs them into a 32-bit result word. Replaces free-running #delay sweeps with a clocked, restartable sweep.

Parameters:
- HOLD_CYCLES, 4: cycles each vector is held before sampling. Legal range 1..255; values below 1 are illegal.
- NUM_VEC, 16: number of vectors in the sweep. Fixed at 2^4; must not be overridden.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  single-cycle request to begin a sweep. Honoured only in IDLE or DONE.
- abort  input  1  terminates the sweep and returns to IDLE. Wins over start.
- vec_out  output  4  {a,b,c,d} to the decoder. Bit 3 = a, bit 0 = d.
- vec_valid  output  1  high while vec_out is being driven (DRIVE or SAMPLE).
- y_in  input  1  decoder output y.
- z_in  input  1  decoder output z.
- busy  output  1  high in DRIVE or SAMPLE.
- done  output  1  high in DONE; sticky until the next start, an abort, or reset.
- result  output  32  captured responses. result[2k+1] = y and result[2k] = z for vector k.
- count  output  5  number of vectors sampled so far, 0..16.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - vec_out=0, vec_valid=0, busy=0, done=0, result=0, count=0, hold counter=0.
- States: IDLE, DRIVE, SAMPLE, DONE. The state register is the only source of busy, done and vec_valid (all registered).
- IDLE:
  - start=1 and abort=0 -> DRIVE.
  - On that transition: vec_out=0, result=0, count=0, hold counter=HOLD_CYCLES-1.
- DRIVE:
  - vec_out stable.
  - Hold counter decrements each cycle; at 0 -> SAMPLE.
  - DRIVE lasts exactly HOLD_CYCLES cycles per vector.
- SAMPLE (exactly 1 cycle):
  - Edge leaving SAMPLE writes {y_in,z_in} into result[2*vec_out+1 : 2*vec_out] and increments count.
  - If vec_out==15 -> DONE; vec_out holds at 15 and vec_valid drops.
  - Otherwise vec_out += 1, counter reloads to HOLD_CYCLES-1, state -> DRIVE.
- DONE:
  - done=1, busy=0.
  - result and count hold.
  - start=1 -> same actions as IDLE start (result cleared, vector 0 driven).
- Latency: each vector occupies HOLD_CYCLES+1 cycles. done rises 16*(HOLD_CYCLES+1) cycles after the edge that samples start.
- Boundary conditions:
  - abort in any state: next edge -> IDLE, vec_out=0, vec_valid=0, done=0. result and count keep their partial values.
  - start and abort in the same cycle: abort wins, no sweep begins.
  - start while busy: ignored; the sweep is not restarted.
  - vec_out wrap-around: never occurs; the 15->0 step happens only through a new start.
  - HOLD_CYCLES=1: DRIVE lasts one cycle; counter reload value is 0.
  - rst_n asserted mid-sweep: immediate return to the reset values above, independent of clk.
- Width rules:
  - Hold counter width = $clog2(HOLD_CYCLES+1), minimum 1.
  - count saturates at 16 (bit 4 set only when complete).

Decomposition:
- Shared package case_seq_pkg:
  - state enum (IDLE=2'd0, DRIVE=2'd1, SAMPLE=2'd2, DONE=2'd3)
  - localparam NUM_VEC=16, VEC_W=4, RES_W=2*NUM_VEC.
- One sub-module, case_hold_timer: loadable down-counter with load, enable and zero flag, parameterised by HOLD_CYCLES.
- FSM, vector register and result packing stay in the top.

Test Plan:
1. Reset, then start pulse with HOLD_CYCLES=4, decoder = code5a -> vec_out steps 0..15, each held 5 cycles. done rises exactly 80 cycles after the start edge. count=16. result matches the golden y/z table for code5a.
2. HOLD_CYCLES=1, y_in tied 1, z_in tied 0 -> done after 32 cycles, result=32'hAAAA_AAAA.
3. abort asserted while vec_out=6 in DRIVE -> next cycle IDLE, vec_out=0, busy=0, done=0, count=6.
4. start and abort in the same cycle from IDLE -> remains IDLE, vec_valid never rises. start pulsed at vector 9 mid-sweep -> ignored, sweep completes unchanged.
5. From DONE, start again with z_in inverted -> result cleared to 0 on the start edge, then refilled. The second done arrives 16*(HOLD_CYCLES+1) cycles later.
6. rst_n pulled low between clock edges during SAMPLE of vector 12 -> outputs zero immediately, without waiting for clk. After release, the block idles until start.
